// File: rtl/hc85_comparator.sv
// Registered 4-bit magnitude comparator with cascade inputs (74HC85 behaviour).
// Q1/Q2/Q3 = A>B / A=B / A<B, updated one clock after the inputs are presented.
module hc85_comparator (
    input  logic clk,
    input  logic rst,
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic B3,
    input  logic B2,
    input  logic B1,
    input  logic B0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    output logic Q1,
    output logic Q2,
    output logic Q3
);

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [2:0] w_res;
    logic       w_decided;
    logic [2:0] r_q;

    assign w_a = {A3, A2, A1, A0};
    assign w_b = {B3, B2, B1, B0};

    always_comb begin
        w_res     = '0;
        w_decided = 1'b0;
        // Scan MSB first; the first differing bit settles the result.
        for (int unsigned k = 0; k < 4; k++) begin
            if (!w_decided && (w_a[3 - k] != w_b[3 - k])) begin
                w_decided = 1'b1;
                w_res     = w_a[3 - k] ? 3'b100 : 3'b001;
            end
        end
        if (!w_decided) begin
            if (I2) begin
                w_res = 3'b010;
            end else begin
                case ({I1, I3})
                    2'b10:   w_res = 3'b100;
                    2'b01:   w_res = 3'b001;
                    2'b11:   w_res = 3'b000;
                    default: w_res = 3'b101;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_res;
        end
    end

    assign {Q1, Q2, Q3} = r_q;

endmodule

// File: tb/tb_hc85_comparator.sv
// Self-checking bench for hc85_comparator: directed cases, exhaustive sweep,
// random traffic and reset behaviour against an arithmetic reference model.
module tb_hc85_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A3 = 1'b0, A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;
    logic B3 = 1'b0, B2 = 1'b0, B1 = 1'b0, B0 = 1'b0;
    logic I1 = 1'b0, I2 = 1'b0, I3 = 1'b0;
    logic Q1, Q2, Q3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hc85_comparator dut (
        .clk(clk), .rst(rst),
        .A3(A3), .A2(A2), .A1(A1), .A0(A0),
        .B3(B3), .B2(B2), .B1(B1), .B0(B0),
        .I1(I1), .I2(I2), .I3(I3),
        .Q1(Q1), .Q2(Q2), .Q3(Q3)
    );

    // Reference: numeric compare of the nibbles, then the 74HC85 cascade table.
    function automatic logic [2:0] model(input int a, input int b, input logic [2:0] cas);
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        if (cas[1]) return 3'b010;
        if (cas[2] && !cas[0]) return 3'b100;
        if (!cas[2] && cas[0]) return 3'b001;
        if (cas[2] && cas[0]) return 3'b000;
        return 3'b101;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cas);
        @(negedge clk);
        {A3, A2, A1, A0} = a;
        {B3, B2, B1, B0} = b;
        {I1, I2, I3} = cas;
    endtask

    // Present inputs, wait one edge, compare against the model.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] cas);
        drive(a, b, cas);
        @(posedge clk);
        #1;
        check(tag, {Q1, Q2, Q3}, model(int'(a), int'(b), cas));
    endtask

    task automatic rand_bits(output logic [3:0] v);
        v = 4'($urandom_range(0, 15));
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] rc;
        logic [3:0] a, b;
        logic [2:0] c;
        logic       exp_onehot;
        logic       got_onehot;
        logic [2:0] casc [5];

        // Reset with arbitrary inputs for two edges.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_bits(ra); rand_bits(rb);
            drive(ra, rb, 3'($urandom_range(0, 7)));
            @(posedge clk);
            #1;
            check("reset", {Q1, Q2, Q3}, 3'b000);
        end
        @(negedge clk);
        rst = 1'b0;
        step("post_reset", 4'b1001, 4'b0110, 3'b010);

        // MSB decides, lower bits random.
        rand_bits(ra); rand_bits(rb);
        step("msb_gt", {1'b1, ra[2:0]}, {1'b0, rb[2:0]}, 3'($urandom_range(0, 7)));
        step("msb_lt", {1'b0, ra[2:0]}, {1'b1, rb[2:0]}, 3'($urandom_range(0, 7)));
        step("bit2_gt", {2'b11, ra[1:0]}, {2'b10, rb[1:0]}, 3'b010);
        step("bit2_lt", {2'b10, ra[1:0]}, {2'b11, rb[1:0]}, 3'b010);
        step("bit1_gt", {3'b111, ra[0]}, {3'b110, rb[0]}, 3'b010);
        step("bit1_lt", {3'b110, ra[0]}, {3'b111, rb[0]}, 3'b010);
        step("bit0_gt", 4'b1111, 4'b1110, 3'b010);
        step("bit0_lt", 4'b1110, 4'b1111, 3'b010);

        // Cascade inputs with equal operands, explicit expected codes.
        casc[0] = 3'b000; casc[1] = 3'b001; casc[2] = 3'b100;
        casc[3] = 3'b101; casc[4] = 3'b111;
        drive(4'hF, 4'hF, casc[0]); @(posedge clk); #1;
        check("cas000", {Q1, Q2, Q3}, 3'b101);
        drive(4'hF, 4'hF, casc[1]); @(posedge clk); #1;
        check("cas001", {Q1, Q2, Q3}, 3'b001);
        drive(4'hF, 4'hF, casc[2]); @(posedge clk); #1;
        check("cas100", {Q1, Q2, Q3}, 3'b100);
        drive(4'hF, 4'hF, casc[3]); @(posedge clk); #1;
        check("cas101", {Q1, Q2, Q3}, 3'b000);
        drive(4'hF, 4'hF, casc[4]); @(posedge clk); #1;
        check("cas111", {Q1, Q2, Q3}, 3'b010);

        // Exhaustive sweep of all 2^11 input combinations, plus one-hot property.
        for (int v = 0; v < 2048; v++) begin
            a = 4'(v >> 7);
            b = 4'(v >> 3);
            c = 3'(v);
            step("sweep", a, b, c);
            exp_onehot = !((a == b) && !c[1] && (c[2] == c[0]));
            got_onehot = ($countones({Q1, Q2, Q3}) == 1);
            check("onehot", {2'b00, got_onehot}, {2'b00, exp_onehot});
        end

        // Random traffic, back-to-back.
        for (int i = 0; i < 300; i++) begin
            rand_bits(ra); rand_bits(rb);
            if ($urandom_range(0, 3) == 0) rb = ra;
            rc = 3'($urandom_range(0, 7));
            step("random", ra, rb, rc);
        end

        // Mid-run reset while A>B, then recovery.
        step("pre_rst", 4'b1010, 4'b0101, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst", {Q1, Q2, Q3}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_resume", {Q1, Q2, Q3}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
